// File: rtl/pipe_stage_buf_pkg.sv
// pipe_stage_buf_pkg: shared stage-bus width constants for the 5-stage core
package pipe_stage_buf_pkg;
  localparam int IF_ID_BUS_W = 64;
  localparam int ID_EX_BUS_W = 151;
  localparam int EX_MA_BUS_W = 71;
  localparam int MA_WB_BUS_W = 70;
endpackage

// File: rtl/pipe_stage_buf_if.sv
// pipe_stage_buf_if: allowin/validout handshake, flush and status bundle for one inter-stage buffer
interface pipe_stage_buf_if #(
  parameter int BUS_W = 64,
  parameter int DEPTH = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  logic prev_validout;
  logic [BUS_W-1:0] in_bus;
  logic allowin;
  logic next_allowin;
  logic validout;
  logic [BUS_W-1:0] out_bus;
  logic flush;
  logic [CNT_W-1:0] occupancy;
  logic [31:0] stall_cnt;
  modport slave (
    input prev_validout, in_bus, next_allowin, flush,
    output allowin, validout, out_bus, occupancy, stall_cnt
  );
  modport master (
    output prev_validout, in_bus, next_allowin, flush,
    input allowin, validout, out_bus, occupancy, stall_cnt
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: DEPTH-entry stage buffer with flush and occupancy; PIPE_BUF_STALL_CNT_EN enables the stall counter
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int BUS_W = IF_ID_BUS_W,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input logic clk,
  input logic rst,
  pipe_stage_buf_if.slave port
);
  localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [BUS_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic allow, valid, push, pop;
  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return p == PTR_W'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  // handshake: a full buffer still accepts when the head leaves this cycle
  always_comb begin
    allow = (count != CNT_W'(DEPTH)) || port.next_allowin;
    valid = count != '0;
    push = port.prev_validout && allow && !port.flush;
    pop = valid && port.next_allowin && !port.flush;
    port.allowin = allow;
    port.validout = valid;
    port.out_bus = valid ? mem[rd_ptr] : '0;
    port.occupancy = count;
  end
  // pointers and count; flush wins over same-cycle push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (port.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop) rd_ptr <= inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
  // storage is data-only, so it carries no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= port.in_bus;
  end
`ifdef PIPE_BUF_STALL_CNT_EN
  logic [31:0] stall_q;
  // counts cycles the head is held back by downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else if (valid && !port.next_allowin && !port.flush) stall_q <= stall_q + 32'd1;
  end
  assign port.stall_cnt = stall_q;
`else
  assign port.stall_cnt = '0;
`endif
endmodule
